text_wr_ctrl: RTL and testbench

//  Command sequencer between the UART receiver and the text buffer (character RAM) read by the VGA pixel path.

---
 rtl/vga_pkg.sv | 17 +
 rtl/cmd_timeout_cnt.sv | 37 +++
 rtl/text_wr_ctrl.sv | 170 +++++++++++++++++
 tb/tb_text_wr_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the text-mode VGA path and its UART command front end.
package vga_pkg;

  localparam int TEXT_COLS    = 80;
  localparam int TEXT_ROWS    = 30;
  localparam int TEXT_ADDR_W  = 12;
  localparam int PIXEL_CLK_HZ = 25_000_000;
  localparam int CMD_TIMEOUT  = 65536;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROW     = 2'd1,
    CHAR    = 2'd2,
    WAIT_WR = 2'd3
  } state_t;

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Saturating idle-cycle counter with synchronous clear; flags the cycle the last count is reached.
module cmd_timeout_cnt #(
  parameter int TIMEOUT = 65536
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int            CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A clear in the same cycle means a byte arrived, which wins over expiry.
  assign expired_o = en_i && !clr_i && (count_q == LAST);

endmodule

// File: rtl/text_wr_ctrl.sv
// Assembles {column, row, ASCII} UART commands into single text-buffer writes,
// deferred until the VGA path is not reading the buffer.
//
// Handshake: rx_valid_i is a one-cycle strobe with no back-pressure; bytes that
// cannot be absorbed (skid full) are dropped and flagged on err_o. wr_en_o is a
// one-cycle strobe with wr_addr_o/wr_data_o valid in the same cycle.
module text_wr_ctrl
  import vga_pkg::*;
#(
  parameter int COLS    = TEXT_COLS,
  parameter int ROWS    = TEXT_ROWS,
  parameter int ADDR_W  = TEXT_ADDR_W,
  parameter int TIMEOUT = CMD_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  input  logic              video_active_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              busy_o,
  output logic              err_o,
  output state_t            state_o
);

  localparam logic [8:0]        COLS_9 = 9'(COLS);
  localparam logic [8:0]        ROWS_9 = 9'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

  state_t            state_q, state_d;
  logic [7:0]        col_q, col_d, row_q, row_d;
  logic              bad_q, bad_d;
  logic [7:0]        skid_q, skid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              err_q, err_d;

  logic              skid_consume, rx_to_skid, overrun, byte_evt;
  logic [7:0]        byte_in;
  logic              timer_clr, timer_en, timer_expired;
  logic [ADDR_W-1:0] row_ext, row_mul, addr_calc;

  // Skid byte is always consumed first once the FSM is out of WAIT_WR.
  assign skid_consume = skid_valid_q && (state_q != WAIT_WR);
  assign rx_to_skid   = rx_valid_i && ((state_q == WAIT_WR) || skid_consume);
  assign overrun      = rx_to_skid && skid_valid_q && !skid_consume;
  assign byte_evt     = skid_consume || (rx_valid_i && (state_q != WAIT_WR) && !skid_valid_q);
  assign byte_in      = skid_valid_q ? skid_q : rx_data_i;

  always_comb begin
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (skid_consume) begin
      skid_valid_d = 1'b0;
    end
    if (rx_to_skid && !overrun) begin
      skid_d       = rx_data_i;
      skid_valid_d = 1'b1;
    end
  end

  assign row_ext = ADDR_W'(row_q);

  always_comb begin
    if (COLS == 80) begin
      row_mul = (row_ext << 6) + (row_ext << 4);
    end else begin
      row_mul = row_ext * COLS_A;
    end
    addr_calc = row_mul + ADDR_W'(col_q);
  end

  assign timer_clr = byte_evt || (state_q == IDLE) || (state_q == WAIT_WR);
  assign timer_en  = (state_q == ROW) || (state_q == CHAR);

  cmd_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .clr_i     (timer_clr),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    bad_d     = bad_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = overrun;
    case (state_q)
      IDLE: begin
        if (byte_evt) begin
          col_d   = byte_in;
          bad_d   = ({1'b0, byte_in} >= COLS_9);
          state_d = ROW;
        end
      end
      ROW: begin
        if (byte_evt) begin
          row_d   = byte_in;
          bad_d   = bad_q || ({1'b0, byte_in} >= ROWS_9);
          state_d = CHAR;
        end else if (timer_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      CHAR: begin
        if (byte_evt) begin
          if (bad_q) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            wr_data_d = byte_in;
            wr_addr_d = addr_calc;
            state_d   = WAIT_WR;
          end
        end else if (timer_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_WR: begin
        if (!video_active_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      bad_q        <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      bad_q        <= bad_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      err_q        <= err_d;
    end
  end

  assign wr_en_o   = (state_q == WAIT_WR) && !video_active_i;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = (state_q != IDLE) || skid_valid_q;
  assign err_o     = err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_text_wr_ctrl.sv
// Directed bench for text_wr_ctrl: writes are scoreboarded through an expected queue.
module tb_text_wr_ctrl;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        video_active;
  logic        wr_en_o;
  logic [11:0] wr_addr_o;
  logic [7:0]  wr_data_o;
  logic        busy_o;
  logic        err_o;
  state_t      state_o;

  int          checks = 0;
  int          errors = 0;
  int          exp_err = 0;
  int          err_seen = 0;
  logic [19:0] exp_q[$];

  text_wr_ctrl dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .video_active_i (video_active),
    .wr_en_o        (wr_en_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .busy_o         (busy_o),
    .err_o          (err_o),
    .state_o        (state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic expect_wr(input int addr, input logic [7:0] data);
    exp_q.push_back({12'(addr), data});
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 1000;
    while ((exp_q.size() != 0 || busy_o) && budget > 0) begin
      cycles(1);
      budget--;
    end
    cycles(3);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_err_count"}, 32'(err_seen), 32'(exp_err));
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_wr_en"}, 32'(wr_en_o), 32'd0);
    check({name, "_addr"}, 32'(wr_addr_o), 32'd0);
    check({name, "_data"}, 32'(wr_data_o), 32'd0);
    check({name, "_busy"}, 32'(busy_o), 32'd0);
    check({name, "_err"}, 32'(err_o), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [19:0] e;
    if (rstn) begin
      if (err_o) err_seen++;
      if (wr_en_o) begin
        check("wr_while_video_active", 32'(video_active), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected", wr_addr_o, wr_data_o);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr_o), 32'(e[19:8]));
          check("wr_data", 32'(wr_data_o), 32'(e[7:0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rstn         = 1'b0;
    rx_data      = 8'h00;
    rx_valid     = 1'b0;
    video_active = 1'b0;
    cycles(3);
    check_outputs_zero("reset");
    rstn = 1'b1;
    cycles(2);

    // 1: origin write, one cycle after the char strobe
    expect_wr(0, 8'h41);
    send(8'h00);
    send(8'h00);
    send(8'h41);
    check("t1_latency", 32'(wr_en_o), 32'd1);
    drain("t1");

    // 2: bottom-right cell, held off by 300 active cycles
    expect_wr(2399, 8'h5A);
    send(8'd79);
    send(8'd29);
    video_active = 1'b1;
    send(8'h5A);
    cycles(300);
    check("t2_held", 32'(exp_q.size()), 32'd1);
    check("t2_busy_held", 32'(busy_o), 32'd1);
    video_active = 1'b0;
    #1;
    check("t2_release", 32'(wr_en_o), 32'd1);
    drain("t2");

    // 3: out-of-range column dropped, then a good command
    send(8'd80);
    send(8'd0);
    send(8'h41);
    exp_err++;
    drain("t3_bad");
    expect_wr(161, 8'h42);
    send(8'd1);
    send(8'd2);
    send(8'h42);
    drain("t3_good");

    // 3b: out-of-range row
    send(8'd5);
    send(8'd30);
    send(8'h47);
    exp_err++;
    drain("t3_badrow");

    // 4: inter-byte timeout
    send(8'd5);
    cycles(65535);
    check("t4_busy_before_expiry", 32'(busy_o), 32'd1);
    cycles(1);
    check("t4_busy_after_expiry", 32'(busy_o), 32'd0);
    check("t4_err_pulse", 32'(err_o), 32'd1);
    exp_err++;
    expect_wr(3, 8'h43);
    send(8'd3);
    send(8'd0);
    send(8'h43);
    drain("t4");

    // 5: byte during WAIT_WR goes through the skid and starts the next command
    expect_wr(10, 8'h44);
    video_active = 1'b1;
    send(8'd10);
    send(8'd0);
    send(8'h44);
    cycles(3);
    send(8'd7);
    cycles(3);
    check("t5_state_wait", 32'(state_o), 32'(WAIT_WR));
    video_active = 1'b0;
    cycles(3);
    check("t5_skid_to_row", 32'(state_o), 32'(ROW));
    expect_wr(7, 8'h45);
    send(8'd0);
    send(8'h45);
    drain("t5");

    // 5b: skid overrun drops the second byte
    expect_wr(81, 8'h30);
    video_active = 1'b1;
    send(8'd1);
    send(8'd1);
    send(8'h30);
    cycles(2);
    send(8'd17);
    send(8'h22);
    exp_err++;
    cycles(2);
    video_active = 1'b0;
    cycles(3);
    expect_wr(17, 8'h31);
    send(8'd0);
    send(8'h31);
    drain("t5b");

    // 6: reset mid-command
    send(8'd4);
    send(8'd1);
    rstn = 1'b0;
    #1;
    check_outputs_zero("t6_in_reset");
    cycles(3);
    check_outputs_zero("t6_end_reset");
    rstn = 1'b1;
    cycles(2);
    check("t6_state_idle", 32'(state_o), 32'(IDLE));
    expect_wr(84, 8'h46);
    send(8'd4);
    send(8'd1);
    send(8'h46);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
